product_accumulator: RTL

- Downstream stage of the shift-and-add multiplier.
- Consumes one multiplier product per accepted beat and accumulates LEN consecutive products into a dot-product sum.
- Emits each completed sum through a one-entry registered output with a valid/ready handshake.
- Back-pressures the multiplier side through in_ready.

---
 rtl/product_accumulator.sv | 134 +++++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// product_accumulator
//
// Downstream stage of the shift-and-add multiplier. Each accepted beat adds
// one unsigned product into a running accumulator. After LEN products the
// completed dot-product sum moves into a one-entry output register. That
// register is drained through a valid/ready handshake.
//
// Build option:
//    PRODUCT_ACC_SATURATE_EN  defined   -> an overflowing add clamps to 2^AW-1
//                             undefined -> an overflowing add wraps modulo 2^AW
//    Both builds set the per-vector overflow flag. The ports and the timing
//    are the same in both builds.
//
// Parameters:
//    PW   product width
//    AW   accumulator / result width (AW >= PW)
//    LEN  products per vector (1..2^CW)
//    CW   beat counter width
//
// Ports:
//    clk        rising-edge clock
//    rst        asynchronous, active-high reset
//    clr        synchronous abort of the vector in progress
//    in_valid   in_prod is valid this cycle
//    in_ready   a beat is accepted this cycle (combinational)
//    in_prod    unsigned product from the multiplier
//    out_valid  out_sum/out_ovf hold a completed vector
//    out_ready  consumer takes the result this cycle
//    out_sum    completed vector sum
//    out_ovf    overflow occurred somewhere in that vector
//    busy       a partial vector is in progress

module product_accumulator #(
   parameter int PW  = 16,
   parameter int AW  = 24,
   parameter int LEN = 8,
   parameter int CW  = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_prod,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_sum,
   output logic          out_ovf,
   output logic          busy
);

   logic [AW-1:0] acc;
   logic [CW-1:0] cnt;
   logic          vovf;

   logic          last_beat;
   logic          accept;
   logic [AW:0]   add_ext;
   logic [AW-1:0] add_sum;
   logic          add_ovf;

   // The beat that completes a vector is the one seen while the counter
   // sits at LEN-1. With LEN=1 every beat is the last one.
   assign last_beat = (cnt == CW'(LEN - 1));

   // Only the final beat has to wait for room in the output register.
   // Earlier beats only touch the accumulator, so they can go ahead while a
   // result is still pending. Draining the register in the same cycle
   // frees the slot, so the final beat does not create a bubble.
   assign in_ready = !clr && !(last_beat && out_valid && !out_ready);
   assign accept   = in_valid && in_ready;

   assign busy = (cnt != '0);

   // The product is zero-extended, and the add is one bit wider than the
   // accumulator so the carry out of bit AW-1 marks an overflow.
   assign add_ext = {1'b0, acc} + (AW + 1)'(in_prod);
   assign add_ovf = add_ext[AW];

   // Saturating build: once the sum has clamped at all-ones, any further
   // non-zero product carries out again, so the vector stays clamped.
`ifdef PRODUCT_ACC_SATURATE_EN
   assign add_sum = add_ovf ? {AW{1'b1}} : add_ext[AW-1:0];
`else
   assign add_sum = add_ext[AW-1:0];
`endif

   // Accumulator, beat counter and per-vector overflow flag.
   // clr drops the partial vector and leaves any pending result alone.
   // The final beat hands its sum to the output register and clears the
   // accumulator for the next vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc  <= '0;
         cnt  <= '0;
         vovf <= 1'b0;
      end else if (clr) begin
         acc  <= '0;
         cnt  <= '0;
         vovf <= 1'b0;
      end else if (accept) begin
         if (last_beat) begin
            acc  <= '0;
            cnt  <= '0;
            vovf <= 1'b0;
         end else begin
            acc  <= add_sum;
            cnt  <= cnt + CW'(1);
            vovf <= vovf | add_ovf;
         end
      end
   end

   // One-entry output register. A drain clears out_valid, but a final beat
   // accepted in the same cycle takes priority: it reloads the register and
   // keeps out_valid high. clr is ignored here so a pending result is kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept && last_beat) begin
            out_valid <= 1'b1;
            out_sum   <= add_sum;
            out_ovf   <= vovf | add_ovf;
         end
      end
   end

endmodule
